// File: rtl/vec_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg
// Shared types and defaults for the vector ALU issue stage.
//   alu_op_t    : 2-bit ALU op code (add, sub, logical right shift, left shift)
//   seq_state_t : sequencer FSM states
//   N_DEF       : default element width
//   VLEN_DEF    : default elements per vector
// ---------------------------------------------------------------------------
package vec_pkg;

  localparam int N_DEF    = 32;
  localparam int VLEN_DEF = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SHR = 2'b10,
    OP_SHL = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/vector_alu_sequencer.sv
// ---------------------------------------------------------------------------
// vector_alu_sequencer
// Issue stage in front of an external combinational scalar ALU. Accepts one
// vector operation, feeds element pairs to the ALU one per cycle and gathers
// the element results and {Zero, Neg} flags into an output vector.
//
// Optional feature macro: VSEQ_BCAST_EN
//   defined   -> adds input Bcast; when high at accept, VecB element 0 is
//                latched into every B element (vector-scalar operation).
//   undefined -> no Bcast port; B is always taken element-wise.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   InValid / InReady   operation handshake (InReady high only in IDLE)
//   VecA, VecB, OpCode  operands (element i = Vec*[i*N +: N]) and op code
//   A, B, ALUControl    element operands / op to the ALU (0 outside RUN)
//   ALUResult, ALUFlags same-cycle ALU result and {Zero, Neg}
//   OutValid / OutReady result handshake (held stable in DONE)
//   VecResult           packed element results
//   VecZero, VecNeg     per-element flags
//   AllZero, AnyNeg     reductions of the flag vectors
// ---------------------------------------------------------------------------
module vector_alu_sequencer
  import vec_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int VLEN = VLEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [VLEN*N-1:0] VecA,
  input  logic [VLEN*N-1:0] VecB,
  input  logic [1:0]        OpCode,
`ifdef VSEQ_BCAST_EN
  input  logic              Bcast,
`endif
  output logic [N-1:0]      A,
  output logic [N-1:0]      B,
  output logic [1:0]        ALUControl,
  input  logic [N-1:0]      ALUResult,
  input  logic [1:0]        ALUFlags,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [VLEN*N-1:0] VecResult,
  output logic [VLEN-1:0]   VecZero,
  output logic [VLEN-1:0]   VecNeg,
  output logic              AllZero,
  output logic              AnyNeg
);

  localparam int IDXW = $clog2(VLEN);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(VLEN - 1);

  seq_state_t      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            in_ready_q;
  alu_op_t         op_q;

  logic [N-1:0]    a_q   [VLEN];
  logic [N-1:0]    b_q   [VLEN];
  logic [N-1:0]    res_q [VLEN];
  logic [VLEN-1:0] zero_q;
  logic [VLEN-1:0] neg_q;

  logic accept;
  logic bcast_sel;

`ifdef VSEQ_BCAST_EN
  assign bcast_sel = Bcast;
`else
  assign bcast_sel = 1'b0;
`endif

  // InReady is registered so it reads 0 while reset is asserted and only
  // rises after release; otherwise it tracks state == IDLE exactly.
  assign InReady = in_ready_q;
  assign accept  = InValid & in_ready_q;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      in_ready_q <= (state_d == S_IDLE);
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        // idx stops at the last element; it never wraps.
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (OutReady) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    A          = '0;
    B          = '0;
    ALUControl = '0;
    OutValid   = 1'b0;
    case (state_q)
      S_RUN: begin
        A          = a_q[idx_q];
        B          = b_q[idx_q];
        ALUControl = op_q;
      end
      S_DONE: begin
        OutValid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------- op code latch ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_ADD;
    end else if (accept) begin
      op_q <= alu_op_t'(OpCode);
    end
  end

  // ---------------- per-element operand and result storage ----------------
  genvar gi;
  generate
    for (gi = 0; gi < VLEN; gi++) begin : g_elem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q[gi] <= '0;
          b_q[gi] <= '0;
        end else if (accept) begin
          a_q[gi] <= VecA[gi*N +: N];
          b_q[gi] <= bcast_sel ? VecB[N-1:0] : VecB[gi*N +: N];
        end
      end

      // Each element slot captures the ALU output only on its own RUN cycle,
      // so the collected vector is untouched while waiting in DONE.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q[gi]  <= '0;
          zero_q[gi] <= 1'b0;
          neg_q[gi]  <= 1'b0;
        end else if (state_q == S_RUN && idx_q == IDXW'(gi)) begin
          res_q[gi]  <= ALUResult;
          zero_q[gi] <= ALUFlags[1];
          neg_q[gi]  <= ALUFlags[0];
        end
      end

      assign VecResult[gi*N +: N] = res_q[gi];
    end
  endgenerate

  assign VecZero = zero_q;
  assign VecNeg  = neg_q;
  assign AllZero = &zero_q;
  assign AnyNeg  = |neg_q;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_alu_sequencer
// Bench for vector_alu_sequencer together with a behavioural scalar ALU.
// Expected result vectors are pushed at accept and popped at the result
// handshake. Define VSEQ_BCAST_EN to also exercise the broadcast operand.
// ---------------------------------------------------------------------------
module tb_vector_alu_sequencer;

  localparam int N    = 32;
  localparam int VLEN = 8;
  localparam int W    = VLEN * N;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    vec_a, vec_b;
  logic [1:0]      op_code;
  logic            bcast;
  logic [N-1:0]    alu_a, alu_b;
  logic [1:0]      alu_ctl;
  logic [N-1:0]    alu_res;
  logic [1:0]      alu_flags;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    vec_res;
  logic [VLEN-1:0] vec_zero, vec_neg;
  logic            all_zero, any_neg;

  always #5 clk = ~clk;

  vector_alu_sequencer #(.N(N), .VLEN(VLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .InValid    (in_valid),
    .InReady    (in_ready),
    .VecA       (vec_a),
    .VecB       (vec_b),
    .OpCode     (op_code),
`ifdef VSEQ_BCAST_EN
    .Bcast      (bcast),
`endif
    .A          (alu_a),
    .B          (alu_b),
    .ALUControl (alu_ctl),
    .ALUResult  (alu_res),
    .ALUFlags   (alu_flags),
    .OutValid   (out_valid),
    .OutReady   (out_ready),
    .VecResult  (vec_res),
    .VecZero    (vec_zero),
    .VecNeg     (vec_neg),
    .AllZero    (all_zero),
    .AnyNeg     (any_neg)
  );

  // Behavioural combinational ALU
  always_comb begin
    case (alu_ctl)
      2'b00:   alu_res = alu_a + alu_b;
      2'b01:   alu_res = alu_a - alu_b;
      2'b10:   alu_res = alu_a >> alu_b[4:0];
      default: alu_res = alu_a << alu_b[4:0];
    endcase
    alu_flags = {(alu_res == '0), alu_res[N-1]};
  end

  typedef struct {
    logic [W-1:0]    res;
    logic [VLEN-1:0] z;
    logic [VLEN-1:0] n;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic [1:0] op, input logic bc);
    exp_t e;
    logic [N-1:0] a, b, r;
    for (int i = 0; i < VLEN; i++) begin
      a = va[i*N +: N];
      b = bc ? vb[N-1:0] : vb[i*N +: N];
      case (op)
        2'b00:   r = a + b;
        2'b01:   r = a - b;
        2'b10:   r = a >> b[4:0];
        default: r = a << b[4:0];
      endcase
      e.res[i*N +: N] = r;
      e.z[i] = (r == '0);
      e.n[i] = r[N-1];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check_val({tag, "_inready"}, W'(in_ready), W'(1));
  endtask

  // Issue one op, check latency, optionally hold in DONE, then drain.
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [1:0] op, input logic bc, input int hold,
                        output logic [VLEN-1:0] z_o, output logic [VLEN-1:0] n_o,
                        output logic az_o, output logic an_o);
    exp_t e;
    int   edges;
    logic [N-1:0] b0;
    wait_ready(tag);
    vec_a    = va;
    vec_b    = vb;
    op_code  = op;
    bcast    = bc;
    in_valid = 1'b1;
    sb_q.push_back(model(va, vb, op, bc));
    tick();
    in_valid = 1'b0;
    edges = 1;
    b0 = bc ? vb[N-1:0] : vb[N-1:0];
    check_val({tag, "_alu_a0"}, W'(alu_a), W'(va[N-1:0]));
    check_val({tag, "_alu_b0"}, W'(alu_b), W'(b0));
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
    check_val({tag, "_latency"}, W'(edges), W'(VLEN + 1));
    e = sb_q[0];
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      vec_a    = ~va;
      check_val({tag, "_hold_res"}, vec_res, e.res);
      check_val({tag, "_hold_inready"}, W'(in_ready), W'(0));
      check_val({tag, "_hold_valid"}, W'(out_valid), W'(1));
      tick();
    end
    in_valid = 1'b0;
    check_val({tag, "_alu_idle"}, W'({alu_a, alu_b, alu_ctl}), W'(0));
    e = sb_q.pop_front();
    check_val({tag, "_res"}, vec_res, e.res);
    check_val({tag, "_zero"}, W'(vec_zero), W'(e.z));
    check_val({tag, "_neg"}, W'(vec_neg), W'(e.n));
    check_val({tag, "_allzero"}, W'(all_zero), W'(&e.z));
    check_val({tag, "_anyneg"}, W'(any_neg), W'(|e.n));
    z_o  = vec_zero;
    n_o  = vec_neg;
    az_o = all_zero;
    an_o = any_neg;
    $display("op %s code=%0d bc=%0d res=%h z=%h n=%h", tag, op, bc, vec_res, vec_zero, vec_neg);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, "_drain_valid"}, W'(out_valid), W'(0));
    check_val({tag, "_drain_inready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0]    va, vb;
    logic [VLEN-1:0] z, n;
    logic            az, an;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    vec_a = '0; vec_b = '0; op_code = 2'b00; bcast = 1'b0;

    // Reset
    #12;
    check_val("rst_inready", W'(in_ready), W'(0));
    check_val("rst_outvalid", W'(out_valid), W'(0));
    check_val("rst_vecres", vec_res, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_val("rel_inready", W'(in_ready), W'(1));

    // Add: A[i]=i, B[i]=10
    for (int i = 0; i < VLEN; i++) begin
      va[i*N +: N] = N'(i);
      vb[i*N +: N] = N'(10);
    end
    run_op("add", va, vb, 2'b00, 1'b0, 0, z, n, az, an);
    check_val("add_allzero_k", W'(az), W'(0));
    check_val("add_anyneg_k", W'(an), W'(0));

    // Sub: all 5 except A[3]=4
    for (int i = 0; i < VLEN; i++) begin
      va[i*N +: N] = N'(5);
      vb[i*N +: N] = N'(5);
    end
    va[3*N +: N] = N'(4);
    run_op("sub", va, vb, 2'b01, 1'b0, 0, z, n, az, an);
    check_val("sub_neg_k", W'(n), W'(8'h08));
    check_val("sub_zero_k", W'(z), W'(8'hF7));
    check_val("sub_anyneg_k", W'(an), W'(1));

    // Backpressure: 5 cycles in DONE with InValid asserted
    for (int i = 0; i < VLEN; i++) begin
      va[i*N +: N] = $urandom;
      vb[i*N +: N] = $urandom;
    end
    run_op("bp", va, vb, 2'b00, 1'b0, 5, z, n, az, an);

    // Reset mid-run at idx=4
    wait_ready("mrst");
    vec_a = va; vec_b = vb; op_code = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check_val("mrst_alu_a4", W'(alu_a), W'(va[4*N +: N]));
    #2 rst_n = 1'b0;
    #1;
    check_val("mrst_outvalid", W'(out_valid), W'(0));
    check_val("mrst_inready", W'(in_ready), W'(0));
    check_val("mrst_alu_idle", W'({alu_a, alu_b, alu_ctl}), W'(0));
    check_val("mrst_vecres", vec_res, '0);
    $display("op mrst aborted at idx 4");
    @(negedge clk);
    rst_n = 1'b1;

    // Ops after the aborted one, including shifts
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < VLEN; i++) begin
        va[i*N +: N] = $urandom;
        vb[i*N +: N] = (k >= 2) ? N'($urandom_range(0, 31)) : N'($urandom);
      end
      run_op($sformatf("post%0d", k), va, vb, 2'(k), 1'b0, 0, z, n, az, an);
    end

    // Zero result vector: AllZero must assert
    run_op("allz", va, va, 2'b01, 1'b0, 0, z, n, az, an);
    check_val("allz_k", W'(az), W'(1));

`ifdef VSEQ_BCAST_EN
    // Broadcast shl: A[i]=1, B[0]=3 -> every element 8
    for (int i = 0; i < VLEN; i++) begin
      va[i*N +: N] = N'(1);
      vb[i*N +: N] = N'(i + 7);
    end
    vb[N-1:0] = N'(3);
    run_op("bcast", va, vb, 2'b11, 1'b1, 0, z, n, az, an);
    check_val("bcast_e7_k", W'(vec_res[7*N +: N]), W'(8));
`endif

    check_val("sb_empty", W'(sb_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
